// File: rtl/rank_filter_pkg.sv
// Shared types and width helpers for the rank-order filter.
// Slot records are sized for the widest legal configuration (32-bit samples,
// windows up to 31 deep); unused upper bits are held at zero and fall away in
// synthesis.
package rank_filter_pkg;

   localparam int MAX_DATA_W = 32;
   localparam int MAX_AGE_W  = 5;

   typedef struct packed {
      logic [MAX_DATA_W-1:0] value;
      logic [MAX_AGE_W-1:0]  age;
      logic                  occ;
   } slot_t;

   typedef enum logic [1:0] {
      OP_KEEP,
      OP_UP,
      OP_DOWN,
      OP_LOAD
   } cell_op_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rank_cell.sv
// One window slot of the rank-order filter. Each slot compares its value with
// the incoming sample, flags itself for eviction when it holds the oldest
// sample, and on an accepted sample keeps its own contents, takes the slot
// below (shift up), takes the slot above (shift down) or loads the new sample.
module rank_cell
   import rank_filter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N      = 5
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              flush,
   input  logic              accept,
   input  cell_op_t          op,
   input  logic [DATA_W-1:0] in_data,
   input  slot_t             below,
   input  slot_t             above,
   output slot_t             slot,
   output slot_t             slot_next,
   output logic              le_new,
   output logic              evict
);

   slot_t src;
   slot_t moved;

   // Select the source record for this slot and age it; a load starts fresh.
   always_comb begin
      src = slot;
      case (op)
         OP_UP:   src = below;
         OP_DOWN: src = above;
         default: src = slot;
      endcase
      moved       = src;
      moved.age   = src.occ ? (src.age + MAX_AGE_W'(1)) : '0;
      if (op == OP_LOAD) begin
         moved.value = MAX_DATA_W'(in_data);
         moved.age   = '0;
         moved.occ   = 1'b1;
      end
      slot_next = accept ? moved : slot;
   end

   // Ties count as "below" so a new sample lands above equal values.
   assign le_new = slot.occ && (slot.value <= MAX_DATA_W'(in_data));
   assign evict  = slot.occ && (slot.age == MAX_AGE_W'(N - 1));

   // Slot register; flush empties the slot.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         slot <= '0;
      end else if (flush) begin
         slot <= '0;
      end else begin
         slot <= slot_next;
      end
   end

endmodule

// File: rtl/rank_order_filter.sv
// Sliding-window rank-order filter: keeps the last N accepted samples sorted
// and emits the sample at the requested rank once the window is full.
// Optional feature macro: RANK_FILTER_MINMAX_EN adds registered out_min and
// out_max ports carrying the window minimum and maximum.
module rank_order_filter
   import rank_filter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N      = 5,
   parameter int IDX_W  = idx_width(N)
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IDX_W-1:0]        rank_sel,
   input  logic                    flush,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [cnt_width(N)-1:0] fill_cnt
`ifdef RANK_FILTER_MINMAX_EN
   ,
   output logic [DATA_W-1:0]       out_min,
   output logic [DATA_W-1:0]       out_max
`endif
);

   localparam int CNT_W = cnt_width(N);

   slot_t            slot_q [N];
   slot_t            slot_d [N];
   cell_op_t         op     [N];
   logic [N-1:0]     le_new;
   logic [N-1:0]     evict;
   logic [CNT_W-1:0] pos;
   logic [CNT_W-1:0] fill_nxt;
   logic [IDX_W-1:0] rank_idx;
   logic             accept;
   logic             ev_run;

   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign fill_nxt = (fill_cnt == CNT_W'(N)) ? fill_cnt : (fill_cnt + CNT_W'(1));

   // Work out where the new sample lands (ignoring any evicted slot) and tell
   // each slot whether to keep, shift up, shift down over the evicted hole, or load.
   always_comb begin
      pos    = '0;
      ev_run = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (le_new[i] && !evict[i]) begin
            pos = pos + CNT_W'(1);
         end
      end
      for (int j = 0; j < N; j++) begin
         op[j] = OP_KEEP;
         if (CNT_W'(j) < pos) begin
            op[j] = (ev_run || evict[j]) ? OP_DOWN : OP_KEEP;
         end else if (CNT_W'(j) == pos) begin
            op[j] = OP_LOAD;
         end else begin
            op[j] = ev_run ? OP_KEEP : OP_UP;
         end
         ev_run = ev_run || evict[j];
      end
   end

   // Out-of-range ranks clamp to the largest slot.
   always_comb begin
      rank_idx = (rank_sel > IDX_W'(N - 1)) ? IDX_W'(N - 1) : rank_sel;
   end

   for (genvar g = 0; g < N; g++) begin : g_cell
      slot_t nb_lo;
      slot_t nb_hi;
      if (g == 0) begin : g_lo_edge
         assign nb_lo = '0;
      end else begin : g_lo_mid
         assign nb_lo = slot_q[g-1];
      end
      if (g == N - 1) begin : g_hi_edge
         assign nb_hi = '0;
      end else begin : g_hi_mid
         assign nb_hi = slot_q[g+1];
      end
      rank_cell #(
         .DATA_W (DATA_W),
         .N      (N)
      ) u_cell (
         .clk       (clk),
         .arst_n    (arst_n),
         .flush     (flush),
         .accept    (accept),
         .op        (op[g]),
         .in_data   (in_data),
         .below     (nb_lo),
         .above     (nb_hi),
         .slot      (slot_q[g]),
         .slot_next (slot_d[g]),
         .le_new    (le_new[g]),
         .evict     (evict[g])
      );
   end

   // Occupancy counter; saturates at N once the window is full.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         fill_cnt <= '0;
      end else if (flush) begin
         fill_cnt <= '0;
      end else if (accept) begin
         fill_cnt <= fill_nxt;
      end
   end

   // Output register: load the post-update rank on acceptance, hold while
   // stalled, drop valid once consumed without a replacement.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef RANK_FILTER_MINMAX_EN
         out_min   <= '0;
         out_max   <= '0;
`endif
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= (fill_nxt == CNT_W'(N));
         out_data  <= DATA_W'(slot_d[rank_idx].value);
`ifdef RANK_FILTER_MINMAX_EN
         out_min   <= DATA_W'(slot_d[0].value);
         out_max   <= DATA_W'(slot_d[N-1].value);
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rank_order_filter.sv
// Self-checking bench for rank_order_filter (N=5, DATA_W=8): a table of
// per-cycle vectors plus a mid-burst reset sequence. Build with
// RANK_FILTER_MINMAX_EN defined to also exercise out_min/out_max.
module tb_rank_order_filter;

   logic       clk;
   logic       arst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] rank_sel;
   logic       flush;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] fill_cnt;
`ifdef RANK_FILTER_MINMAX_EN
   logic [7:0] out_min;
   logic [7:0] out_max;
`endif

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic       vin;
      logic [7:0] din;
      logic [2:0] rsel;
      logic       ordy;
      logic       fl;
      logic       e_rdy;
      logic       e_ov;
      logic       chk_d;
      logic [7:0] e_od;
      logic [2:0] e_fill;
   } vec_t;

   vec_t vecs[$];

   rank_order_filter #(
      .DATA_W (8),
      .N      (5),
      .IDX_W  (3)
   ) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rank_sel  (rank_sel),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fill_cnt  (fill_cnt)
`ifdef RANK_FILTER_MINMAX_EN
      ,
      .out_min   (out_min),
      .out_max   (out_max)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic addVec(input logic vin, input int din, input int rsel, input logic ordy,
                         input logic fl, input logic e_rdy, input logic e_ov,
                         input logic chk_d, input int e_od, input int e_fill);
      vec_t v;
      v.vin    = vin;
      v.din    = 8'(din);
      v.rsel   = 3'(rsel);
      v.ordy   = ordy;
      v.fl     = fl;
      v.e_rdy  = e_rdy;
      v.e_ov   = e_ov;
      v.chk_d  = chk_d;
      v.e_od   = 8'(e_od);
      v.e_fill = 3'(e_fill);
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, check in_ready before the edge and the
   // registered outputs just after it.
   task automatic applyStimulus(input vec_t v, input string tag);
      in_valid  = v.vin;
      in_data   = v.din;
      rank_sel  = v.rsel;
      out_ready = v.ordy;
      flush     = v.fl;
      #1;
      checkOutput({tag, " in_ready"}, int'(in_ready), int'(v.e_rdy));
      @(posedge clk);
      #1;
      checkOutput({tag, " out_valid"}, int'(out_valid), int'(v.e_ov));
      if (v.chk_d) begin
         checkOutput({tag, " out_data"}, int'(out_data), int'(v.e_od));
      end
      checkOutput({tag, " fill_cnt"}, int'(fill_cnt), int'(v.e_fill));
   endtask

   initial begin
      arst_n    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      rank_sel  = '0;
      flush     = 1'b0;
      out_ready = 1'b0;

      //      vin din rs ordy fl  rdy ov chk od fill
      addVec(1, 10, 2, 1, 0,  1, 0, 0, 0,  1);
      addVec(1, 50, 2, 1, 0,  1, 0, 0, 0,  2);
      addVec(1, 20, 2, 1, 0,  1, 0, 0, 0,  3);
      addVec(1, 40, 2, 1, 0,  1, 0, 0, 0,  4);
      addVec(1, 30, 2, 1, 0,  1, 1, 1, 30, 5);
      addVec(1, 5,  0, 1, 0,  1, 1, 1, 5,  5);
      addVec(1, 60, 4, 1, 0,  1, 1, 1, 60, 5);
      addVec(1, 70, 4, 0, 0,  0, 1, 1, 60, 5);
      addVec(1, 70, 4, 0, 0,  0, 1, 1, 60, 5);
      addVec(1, 70, 4, 0, 0,  0, 1, 1, 60, 5);
      addVec(1, 70, 4, 1, 0,  1, 1, 1, 70, 5);
      addVec(1, 1,  0, 1, 0,  1, 1, 1, 1,  5);
      addVec(0, 0,  0, 1, 0,  1, 0, 1, 1,  5);
      addVec(0, 0,  0, 0, 0,  1, 0, 0, 0,  5);
      addVec(1, 99, 0, 0, 1,  0, 0, 0, 0,  0);
      addVec(1, 7,  1, 1, 0,  1, 0, 0, 0,  1);
      addVec(1, 7,  1, 1, 0,  1, 0, 0, 0,  2);
      addVec(1, 7,  1, 1, 0,  1, 0, 0, 0,  3);
      addVec(1, 3,  1, 1, 0,  1, 0, 0, 0,  4);
      addVec(1, 7,  1, 1, 0,  1, 1, 1, 7,  5);
      addVec(1, 3,  1, 1, 0,  1, 1, 1, 3,  5);
      addVec(1, 50, 0, 0, 1,  0, 0, 0, 0,  0);
      addVec(1, 1,  4, 1, 0,  1, 0, 0, 0,  1);
      addVec(1, 2,  4, 1, 0,  1, 0, 0, 0,  2);
      addVec(1, 3,  4, 1, 0,  1, 0, 0, 0,  3);
      addVec(1, 4,  4, 1, 0,  1, 0, 0, 0,  4);
      addVec(1, 5,  4, 1, 0,  1, 1, 1, 5,  5);
      addVec(1, 0,  7, 1, 0,  1, 1, 1, 5,  5);
      addVec(1, 9,  2, 1, 0,  1, 1, 1, 4,  5);

      // Reset values while arst_n is held low.
      #12;
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_data", int'(out_data), 0);
      checkOutput("reset fill_cnt", int'(fill_cnt), 0);
      checkOutput("reset in_ready", int'(in_ready), 1);
      arst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[k]) begin
         applyStimulus(vecs[k], $sformatf("v%0d", k));
      end

      // Reset dropped mid-burst acts without waiting for a clock edge.
      in_valid  = 1'b1;
      in_data   = 8'd77;
      out_ready = 1'b1;
      #2;
      arst_n = 1'b0;
      #1;
      checkOutput("midrst out_valid", int'(out_valid), 0);
      checkOutput("midrst out_data", int'(out_data), 0);
      checkOutput("midrst fill_cnt", int'(fill_cnt), 0);
`ifdef RANK_FILTER_MINMAX_EN
      checkOutput("midrst out_min", int'(out_min), 0);
      checkOutput("midrst out_max", int'(out_max), 0);
`endif
      in_valid = 1'b0;
      #1;
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("postrst fill_cnt", int'(fill_cnt), 0);

      // Refill after reset and check the rank output plus optional min/max.
      vecs.delete();
      addVec(1, 10, 2, 1, 0,  1, 0, 0, 0,  1);
      addVec(1, 50, 2, 1, 0,  1, 0, 0, 0,  2);
      addVec(1, 20, 2, 1, 0,  1, 0, 0, 0,  3);
      addVec(1, 40, 2, 1, 0,  1, 0, 0, 0,  4);
      addVec(1, 30, 2, 1, 0,  1, 1, 1, 30, 5);
      foreach (vecs[k]) begin
         applyStimulus(vecs[k], $sformatf("refill%0d", k));
      end
`ifdef RANK_FILTER_MINMAX_EN
      checkOutput("refill out_min", int'(out_min), 10);
      checkOutput("refill out_max", int'(out_max), 50);
`endif
      in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rank_order_filter.md
RANK_ORDER_FILTER -- requirements
Module: rank_order_filter

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits, legal range 2..32.
REQ-002 Parameter N, default 5: window depth in samples, legal range 3..31.
REQ-003 Parameter IDX_W, default $clog2(N): width of rank_sel.
REQ-004 clk  in  1: single clock; all state is updated on the rising edge.
REQ-005 arst_n  in  1: asynchronous, active-low reset.
REQ-006 in_data  in  DATA_W: incoming sample, unsigned.
REQ-007 in_valid  in  1: in_data is valid.
REQ-008 in_ready  out  1: the block can accept a sample.
REQ-009 rank_sel  in  IDX_W: rank to output, where 0 is the smallest.
REQ-010 flush  in  1: synchronous clear of the window.
REQ-011 out_data  out  DATA_W: sample at the selected rank.
REQ-012 out_valid  out  1: out_data is valid.
REQ-013 out_ready  in  1: the consumer accepts out_data.
REQ-014 fill_cnt  out  $clog2(N+1): number of occupied window slots.

Function
REQ-015 The block SHALL hold N slots, each with {value, age, occ}, kept sorted ascending by value over the occupied slots, which occupy indices 0..fill_cnt-1.
REQ-016 in_ready SHALL equal !flush && (!out_valid || out_ready).
REQ-017 A sample is accepted when in_valid && in_ready; accepted samples are the only events that change slot contents.
REQ-018 On acceptance with fill_cnt<N: all occupied ages +1; the new sample is inserted at its sorted position with age 0; higher slots shift up by one; fill_cnt +1.
REQ-019 On acceptance with fill_cnt==N: the slot with age N-1 is evicted and the new sample is inserted in the same cycle; the result is a sorted window of the last N accepted samples.
REQ-020 Ties: the new sample SHALL be placed above all existing equal values, giving stable and deterministic ordering.
REQ-021 Every insert and evict SHALL complete in one cycle, with no multi-phase operation.
REQ-022 out_data SHALL be registered as the post-update slot[min(rank_sel, N-1)].value; rank_sel is sampled in the acceptance cycle.
REQ-023 out_valid SHALL assert in the cycle after an acceptance that leaves fill_cnt==N; accept-to-output latency is 1 cycle.
REQ-024 out_valid with !out_ready: out_data and out_valid SHALL hold stable, and in_ready is low.
REQ-025 out_valid && out_ready with no new acceptance: out_valid SHALL deassert next cycle.
REQ-026 Output accepted and a new sample accepted in the same cycle: out_valid SHALL stay high and out_data update, giving a full-throughput stream of 1 sample per cycle.
REQ-027 flush SHALL clear all occ bits, set fill_cnt=0, and set out_valid=0 next cycle; flush has priority over in_valid, and the concurrent sample is not accepted.
REQ-028 After a flush, output SHALL resume only after N new acceptances.

Reset
REQ-029 While arst_n is low: all slots are value 0, age 0, occ 0; fill_cnt=0; out_valid=0; out_data=0.
REQ-030 Reset asserted mid-stream SHALL take effect immediately and discard the window and any pending output.
REQ-031 in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-032 Macro RANK_FILTER_MINMAX_EN, when defined, SHALL add output ports out_min and out_max, each DATA_W wide, registered alongside out_data as slot[0].value and slot[N-1].value under the same valid/hold rules.
REQ-033 When RANK_FILTER_MINMAX_EN is undefined, these ports and their registers SHALL be absent, and all other behaviour is identical.

Structure
REQ-034 Package rank_filter_pkg SHALL hold the slot record typedef {value, age, occ} and the helper functions for IDX_W and count-width calculation.
REQ-035 Sub-module rank_cell SHALL implement one slot: comparator, keep/shift-up/shift-down/load mux, age update and evict flag.
REQ-036 The top level SHALL instantiate N rank_cell instances plus the handshake and output registers.

Verification
REQ-037 N=5, rank_sel=2, in 10,50,20,40,30 -> out_valid once, after the 5th acceptance, with out_data=30 and fill_cnt=5.
REQ-038 Continue with in 5 and rank_sel=0 -> window {50,20,40,30,5} gives out_data=5; next in 60 with rank_sel=4 -> window {20,40,30,5,60} gives out_data=60.
REQ-039 Hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, out_data stable, no sample lost; release -> 1 sample per cycle.
REQ-040 in 7,7,7,3,7 with rank_sel=1 -> out_data=7; then in 3 -> evicts the oldest 7, giving {7,7,3,7,3} and out_data=3.
REQ-041 Pulse flush when fill_cnt=5 -> fill_cnt=0 and out_valid=0; 4 new samples give no output; the 5th gives output.
REQ-042 Drop arst_n mid-burst -> all outputs 0 immediately; with RANK_FILTER_MINMAX_EN defined and in 10,50,20,40,30 -> out_min=10, out_max=50.
